// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator feeding an 8-bit PWM stage.
// Walks duty_cycle toward an accepted target, stepping only on PWM period boundaries.
module pwm_duty_ramp #(
    parameter logic [7:0] INIT_DUTY = 8'd128,
    parameter logic [7:0] STEP      = 8'd1,
    parameter logic [7:0] RATE_DIV  = 8'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] target_duty,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [7:0] duty_cycle,
    output logic       period_tick,
    output logic       ramp_busy,
    output logic       ramp_done
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    localparam logic [7:0] DIV_LAST = RATE_DIV - 8'd1;

    state_t     state_q, state_d;
    logic [7:0] duty_q, duty_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] div_q, div_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       boundary;
    logic       upd;
    logic       accept;
    logic       fin;
    logic [8:0] up_sum;
    logic [8:0] dn_lim;

    assign target_ready = (state_q == IDLE) && !reset;
    assign duty_cycle   = duty_q;
    assign period_tick  = (cnt_q == 8'hFF);
    assign ramp_busy    = busy_q;
    assign ramp_done    = done_q;

    assign boundary = (cnt_q == 8'hFF);
    assign upd      = boundary && (div_q == DIV_LAST);
    assign accept   = target_valid && target_ready;
    assign up_sum   = {1'b0, duty_q} + {1'b0, STEP};
    // duty - STEP <= target rewritten to avoid a signed subtract
    assign dn_lim   = {1'b0, tgt_q} + {1'b0, STEP};

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q + 8'd1;
        div_d   = div_q;
        done_d  = 1'b0;
        fin     = 1'b0;

        if (boundary) begin
            div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d = target_duty;
                    div_d = 8'd0;
                    if (target_duty > duty_q) begin
                        state_d = RAMP_UP;
                    end else if (target_duty < duty_q) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RAMP_UP: begin
                if (upd) begin
                    if (up_sum >= {1'b0, tgt_q}) begin
                        duty_d  = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        fin     = 1'b1;
                    end else begin
                        duty_d = up_sum[7:0];
                    end
                end
            end
            RAMP_DOWN: begin
                if (upd) begin
                    if ({1'b0, duty_q} <= dn_lim) begin
                        duty_d  = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        fin     = 1'b1;
                    end else begin
                        duty_d = duty_q - STEP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy stays up through the ramp_done cycle
        busy_d = (state_d != IDLE) || fin;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= INIT_DUTY;
            tgt_q   <= 8'd0;
            cnt_q   <= 8'd0;
            div_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: three instances with different parameters
// share clock and reset so their period counters stay aligned.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] tgt_a, tgt_b, tgt_c;
    logic       val_a, val_b, val_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] duty_a, duty_b, duty_c;
    logic       tick_a, tick_b, tick_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp u_a (
        .clock(clk), .reset(rst),
        .target_duty(tgt_a), .target_valid(val_a), .target_ready(rdy_a),
        .duty_cycle(duty_a), .period_tick(tick_a),
        .ramp_busy(busy_a), .ramp_done(done_a)
    );

    pwm_duty_ramp #(.INIT_DUTY(8'd10), .STEP(8'd4), .RATE_DIV(8'd1)) u_b (
        .clock(clk), .reset(rst),
        .target_duty(tgt_b), .target_valid(val_b), .target_ready(rdy_b),
        .duty_cycle(duty_b), .period_tick(tick_b),
        .ramp_busy(busy_b), .ramp_done(done_b)
    );

    pwm_duty_ramp #(.INIT_DUTY(8'd128), .STEP(8'd100), .RATE_DIV(8'd2)) u_c (
        .clock(clk), .reset(rst),
        .target_duty(tgt_c), .target_valid(val_c), .target_ready(rdy_c),
        .duty_cycle(duty_c), .period_tick(tick_c),
        .ramp_busy(busy_c), .ramp_done(done_c)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!tick_a && n < 300) begin
            step();
            n++;
        end
        if (!tick_a) chk("tick_timeout", 0, 1);
    endtask

    task automatic bound();
        wait_tick();
        step();
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1;
        tgt_a = 8'd0; tgt_b = 8'd0; tgt_c = 8'd0;
        val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        step();
        step();
        chk("rst_duty", duty_a, 128);
        chk("rst_ready", rdy_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_tick", tick_a, 0);
        chk("rst_duty_b", duty_b, 10);
        rst = 1'b0;

        // idle: 600 clocks, duty constant, tick when counter==255
        bad = 0;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (duty_a !== 8'd128 || busy_a !== 1'b0 || rdy_a !== 1'b1) bad++;
            if (i == 255) chk("tick_255", tick_a, 1);
            if (i == 256) chk("tick_256", tick_a, 0);
            if (i == 511) chk("tick_511", tick_a, 1);
        end
        chk("idle_stable", bad, 0);

        // ramp up 128 -> 131, step 1
        tgt_a = 8'd131; val_a = 1'b1;
        step();
        val_a = 1'b0;
        chk("up_busy", busy_a, 1);
        chk("up_ready", rdy_a, 0);
        chk("up_duty0", duty_a, 128);
        bound();
        chk("up_129", duty_a, 129);
        chk("up_nodone", done_a, 0);
        wait_tick();
        chk("up_hold", duty_a, 129);
        step();
        chk("up_130", duty_a, 130);
        bound();
        chk("up_131", duty_a, 131);
        chk("up_done", done_a, 1);
        step();
        chk("up_done_off", done_a, 0);
        chk("up_busy_off", busy_a, 0);
        chk("up_ready_on", rdy_a, 1);

        // ramp down with clamp at 0: 10 -> 6 -> 2 -> 0
        tgt_b = 8'd0; val_b = 1'b1;
        step();
        val_b = 1'b0;
        chk("dn_busy", busy_b, 1);
        bound();
        chk("dn_6", duty_b, 6);
        bound();
        chk("dn_2", duty_b, 2);
        chk("dn_nodone", done_b, 0);
        bound();
        chk("dn_0", duty_b, 0);
        chk("dn_done", done_b, 1);

        // overflow clamp, update every 2nd boundary
        tgt_c = 8'd255; val_c = 1'b1;
        step();
        val_c = 1'b0;
        bound();
        chk("ov_b1", duty_c, 128);
        bound();
        chk("ov_b2", duty_c, 228);
        bound();
        chk("ov_b3", duty_c, 228);
        chk("ov_b3_busy", busy_c, 1);
        bound();
        chk("ov_b4", duty_c, 255);
        chk("ov_done", done_c, 1);

        // equal target: done pulse, no busy
        tgt_b = 8'd0; val_b = 1'b1;
        step();
        val_b = 1'b0;
        chk("eq_done", done_b, 1);
        chk("eq_busy", busy_b, 0);
        chk("eq_duty", duty_b, 0);
        step();
        chk("eq_done_off", done_b, 0);

        // handshake: hold valid with 50 during a ramp to 200
        tgt_a = 8'd200; val_a = 1'b1;
        step();
        tgt_a = 8'd50;
        bad = 0;
        n = 0;
        while (!done_a && n < 80 * 256) begin
            if (rdy_a) bad++;
            step();
            n++;
        end
        chk("hs_done_seen", done_a, 1);
        chk("hs_ready_low", bad, 0);
        chk("hs_duty200", duty_a, 200);
        step();
        val_a = 1'b0;
        chk("hs_accept_busy", busy_a, 1);
        chk("hs_accept_rdy", rdy_a, 0);
        chk("hs_duty_keep", duty_a, 200);
        bound();
        chk("hs_199", duty_a, 199);

        // mid-ramp reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_init", duty_a, 128);
        tgt_a = 8'd200; val_a = 1'b1;
        step();
        val_a = 1'b0;
        bound();
        chk("mr_129", duty_a, 129);
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        #2;
        chk("mr_async_duty", duty_a, 128);
        chk("mr_async_busy", busy_a, 0);
        chk("mr_async_rdy", rdy_a, 0);
        chk("mr_async_tick", tick_a, 0);
        chk("mr_async_done", done_a, 0);
        #2;
        rst = 1'b0;
        tgt_a = 8'd130; val_a = 1'b1;
        step();
        val_a = 1'b0;
        bound();
        chk("mr2_129", duty_a, 129);
        bound();
        chk("mr2_130", duty_a, 130);
        chk("mr2_done", done_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream companion to the 8-bit PWM generator. It produces the 8-bit duty-cycle value that feeds the PWM stage's duty input. When software or an upstream controller hands it a new target duty, it walks the duty toward that target by a programmable step. The duty changes only at PWM period boundaries, so the PWM output never sees a mid-period duty jump (LED fades, soft-start of motor drives).

Parameters:
INIT_DUTY, 8'd128, duty_cycle value after reset.
STEP, 8'd1, increment/decrement applied per update; legal range 1..255.
RATE_DIV, 8'd1, number of PWM periods between updates; legal range 1..255.

Ports:
clock  input  1  system clock; all registers update on the rising edge.
reset  input  1  asynchronous, active-high reset.
target_duty  input  8  requested final duty value.
target_valid  input  1  target_duty is valid this cycle.
target_ready  output  1  block can accept a target; high only in IDLE and not in reset.
duty_cycle  output  8  registered duty value driven to the PWM stage.
period_tick  output  1  one-cycle pulse marking the last clock of each 256-clock PWM period.
ramp_busy  output  1  high while in RAMP_UP or RAMP_DOWN.
ramp_done  output  1  one-cycle pulse on the cycle duty_cycle reaches the target.

Behaviour:
- Reset (asynchronous, active-high): duty_cycle=INIT_DUTY; period counter=0; div counter=0; state=IDLE; period_tick=0; ramp_busy=0; ramp_done=0; target_ready=0 while reset is asserted.
- Period counter: 8-bit, free-running from 0 to 255, wraps to 0.
  - period_tick = (counter==255).
  - The clock edge where the counter wraps 255->0 is the "boundary edge".
- Div counter: counts boundary edges 0..RATE_DIV-1, then wraps. An update is due on a boundary edge where div==RATE_DIV-1.
- Handshake: a target is accepted on a rising edge where target_valid && target_ready. target_duty is sampled into an internal target register.
  - Target accepted with target==duty_cycle: stay IDLE, no busy, and ramp_done pulses next cycle.
  - target>duty_cycle: go to RAMP_UP.
  - target<duty_cycle: go to RAMP_DOWN.
  - Div counter clears to 0 on accept; the period counter is not disturbed.
- While busy, target_valid is ignored because target_ready=0. No queuing; upstream holds valid until ready.
- RAMP_UP, on an update edge: next = duty+STEP, computed 9-bit.
  - If next>=target: duty=target, state goes to IDLE, ramp_done=1 for one cycle.
  - Otherwise: duty=next[7:0].
  - No 8-bit overflow/wrap is permitted.
- RAMP_DOWN, on an update edge: next = duty-STEP, computed 9-bit signed.
  - If next<=target (including negative): duty=target, state goes to IDLE, ramp_done=1.
  - Otherwise: duty=next[7:0].
- duty_cycle changes only on boundary edges, so its value is constant for any full period from counter 0 to 255.
- An accept that coincides with a boundary edge does not step on that edge. The first step is at least RATE_DIV boundaries later.
- ramp_busy is registered and follows the state: high from the cycle after accept until the cycle ramp_done is high, inclusive.
- Reset asserted mid-ramp aborts immediately: duty_cycle returns to INIT_DUTY and the target is discarded.
- target_ready is combinational: (state==IDLE) && !reset.

Test Plan:
- Reset/idle: assert reset, release, run 600 clocks with defaults -> duty_cycle=128 throughout; period_tick high at clocks 256 and 512 (counter==255); busy=0; ready=1.
- Ramp up: accept target 131 with STEP=1, RATE_DIV=1 -> duty goes 129, 130, 131 on the next three boundary edges; ramp_done pulses once with duty=131; busy drops; ready returns to 1.
- Ramp down with clamp: INIT_DUTY=10, STEP=4, accept target 0 -> duty goes 6, 2, 0 (no wrap to 254); ramp_done on the 0 update.
- Overflow clamp and rate: STEP=100, RATE_DIV=2, from 128 accept target 255 -> duty goes 228 after the 2nd boundary and 255 after the 4th; never wraps; no change on odd boundaries.
- Handshake: hold target_valid=1 with target 50 during a ramp to 200 -> not accepted until ready returns; then accepted and RAMP_DOWN begins. A target equal to the current duty gives a ramp_done pulse with no busy.
- Mid-ramp reset: assert reset at counter 100 during a ramp from 128 to 200 -> duty_cycle=128 and outputs go to reset values asynchronously, before the next clock; after release the next ramp completes normally.
